// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchroniser and mid-bit sampling.
// A start bit is accepted only after the line has been seen high in IDLE.
module uart_rx #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BAUD_RATE = 115_200,
   parameter int CLK_DIV   = CLK_HZ / BAUD_RATE
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       busy_o
);
   localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e      state_q, state_d;
   logic [1:0]  sync_q, sync_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        armed_q, armed_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        rx_s, baud_end;

   assign rx_s     = sync_q[1];
   assign baud_end = baud_q == DIV_M1;

   always_comb begin
      state_d = state_q;
      sync_d  = {sync_q[0], rx_i};
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      armed_d = armed_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rx_s) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = START;
               baud_d  = 16'd0;
               armed_d = 1'b0;
            end
         end
         START: begin
            if (baud_q == HALF_M1) begin
               state_d = rx_s ? IDLE : DATA;
               baud_d  = 16'd0;
               bit_d   = 3'd0;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (baud_end) begin
               shift_d = {rx_s, shift_q[7:1]};
               baud_d  = 16'd0;
               state_d = (bit_q == 3'd7) ? STOP : DATA;
               bit_d   = (bit_q == 3'd7) ? bit_q : bit_q + 3'd1;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (baud_end) begin
               state_d = IDLE;
               baud_d  = 16'd0;
               data_d  = rx_s ? shift_q : data_q;
               valid_d = rx_s;
               ferr_d  = !rx_s;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         armed_q <= 1'b0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         armed_q <= armed_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
   assign busy_o      = state_q != IDLE;
endmodule
